hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Generates the 3-bit forwarding selects that drive the two 5-input EX-stage operand muxes (operand A and B).
- Also produces pipeline stall/bubble control for load-use and multi-cycle mul/div hazards.
- Sits in the ID stage: forwarding decisions are made in ID against in-flight destination records and registered into EX, so the muxes see a stable select for the whole EX cycle.

Parameters:
- REG_AW, 5, register-address width
- SEL_W, 3, forwarding-select width; must match the EX operand mux sel port

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register A
- id_rt  in  REG_AW  source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_uses_hilo  in  1  instruction reads HI/LO
- id_wr_en  in  1  instruction writes rd
- id_rd  in  REG_AW  destination register
- id_is_load  in  1  destination value comes from memory
- id_is_link  in  1  destination value is the link address (PC+8)
- id_md_start  in  1  instruction launches a mul/div
- md_done  in  1  mul/div unit result ready (single-cycle pulse)
- mem_stall  in  1  global freeze (cache miss)
- fwd_sel_a  out  SEL_W  EX operand A mux select
- fwd_sel_b  out  SEL_W  EX operand B mux select
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX

Behaviour:
- Select encoding:
  - 000 regfile/ID-EX value
  - 001 EX/MEM ALU result
  - 010 MEM/WB ALU result
  - 011 MEM/WB load data
  - 100 EX/MEM link value
  - 101–111 never driven
- Internal records: ex_rec and mem_rec, each holding {valid, wr_en, rd, is_load, is_link}.
- Advance cycle (mem_stall=0):
  - mem_rec <= ex_rec.
  - ex_rec <= ID fields when not stalling; otherwise a cleared record.
- mem_stall=1: all records, FSM state, and fwd_sel_* hold their values.
- A record matches an operand when rec.valid && rec.wr_en && rec.rd != 0 && rec.rd == operand && operand is used.
- Per-operand select, computed combinationally and registered into fwd_sel_x on advance. The newest producer wins:
  - ex_rec match, not load, link → 100
  - ex_rec match, not load, not link → 001
  - otherwise mem_rec match, load → 011
  - otherwise mem_rec match, not load → 010
  - otherwise → 000
- Writes from the WB stage are covered by the write-first regfile; this block ignores them.
- Load-use: an ex_rec match with is_load raises a load-use stall.
  - stall_if_id=1 and bubble_ex=1 combinationally.
  - fwd_sel_* register 000 (bubble).
  - Next cycle the load is in mem_rec, and the operand resolves to 011.
- FSM states: RUN, LU_STALL, MD_WAIT.
  - RUN→LU_STALL on load-use. LU_STALL lasts exactly 1 advance cycle, then returns to RUN after re-evaluation.
  - RUN→MD_WAIT when id_md_start is accepted (id_valid, no stall).
  - MD_WAIT→RUN on md_done.
  - In MD_WAIT, id_valid && id_uses_hilo stalls (stall_if_id=1, bubble_ex=1) until md_done.
  - md_done in the same cycle as the HI/LO read: no stall; the instruction proceeds.
- Simultaneous load-use and HI/LO wait: a single stall. The FSM stays in MD_WAIT and re-evaluates load-use each cycle.
- id_md_start while already in MD_WAIT: treated as a HI/LO hazard and stalled until md_done.
- id_valid=0: no stall; a bubble record enters EX.
- Reset (asynchronous, any time, including mid-stall):
  - FSM=RUN, records cleared.
  - fwd_sel_a=fwd_sel_b=000, stall_if_id=0, bubble_ex=0 immediately.
- Latency: select is valid in EX exactly 1 cycle after the instruction was in ID (excluding stall cycles).

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs perf_lu_cnt[31:0] and perf_md_cnt[31:0], counting load-use and MD_WAIT stall cycles.
  - Counters do not count while mem_stall=1.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package cpu_pipe_pkg: fwd_sel_e encoding constants (FWD_RF, FWD_EXM_ALU, FWD_MWB_ALU, FWD_MWB_LD, FWD_EXM_LINK), hz_state_e, and the dest-record struct.
- Sub-module hazard_fwd_cmp: per-operand priority compare producing {sel, load_use}, instantiated twice (A and B).

Test Plan:
- add r3 then add r4,r3,r3 → next-cycle fwd_sel_a=fwd_sel_b=001, no stall.
- lw r5 then sub r6,r5,r1 → 1 cycle with stall_if_id=1, bubble_ex=1, sel=000; then fwd_sel_a=011, fwd_sel_b=000.
- Producer write to r0 followed by a read of r0 → sel 000 and no stall.
- jal (rd=r31) followed by a read of r31 → fwd_sel=100. Same producer two instructions back (non-link ALU write) → 010.
- mult, then mfhi issued 2 cycles later, md_done at cycle 6 → stall through cycle 6 unless md_done coincides, then proceed; FSM returns to RUN.
- rst_n low during LU_STALL → outputs cleared asynchronously. mem_stall=1 for 3 cycles mid-forward → fwd_sel holds its value.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for hazard detection: forwarding-select encoding, hazard FSM
// states and the in-flight destination record carried through EX and MEM.
package cpu_pipe_pkg;

    localparam int HZ_REG_AW = 5;
    localparam int HZ_SEL_W  = 3;

    typedef enum logic [HZ_SEL_W-1:0] {
        FWD_RF       = 3'b000,
        FWD_EXM_ALU  = 3'b001,
        FWD_MWB_ALU  = 3'b010,
        FWD_MWB_LD   = 3'b011,
        FWD_EXM_LINK = 3'b100
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LU_STALL,
        HZ_MD_WAIT
    } hz_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [HZ_REG_AW-1:0] rd;
        logic                 is_load;
        logic                 is_link;
    } dest_rec_t;

    // r0 is hardwired zero, so a write to it never produces a forwardable value.
    function automatic logic rec_hit(input dest_rec_t r, input logic [HZ_REG_AW-1:0] opnd,
                                     input logic used);
        return used && r.valid && r.wr_en && (r.rd != '0) && (r.rd == opnd);
    endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand producer compare: picks the newest in-flight producer of one source
// register and flags a load-use hazard when that producer is a load still in EX.
module hazard_fwd_cmp
    import cpu_pipe_pkg::*;
(
    input  dest_rec_t            ex_rec,
    input  dest_rec_t            mem_rec,
    input  logic [HZ_REG_AW-1:0] opnd,
    input  logic                 used,
    output fwd_sel_e             sel,
    output logic                 load_use
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = rec_hit(ex_rec, opnd, used);
    assign mem_hit = rec_hit(mem_rec, opnd, used);

    always_comb begin
        sel      = FWD_RF;
        load_use = 1'b0;
        if (ex_hit) begin
            // A load in EX has no data yet; the stall turns this into a MEM/WB hit next cycle.
            if (ex_rec.is_load) load_use = 1'b1;
            else                sel      = ex_rec.is_link ? FWD_EXM_LINK : FWD_EXM_ALU;
        end else if (mem_hit) begin
            sel = mem_rec.is_load ? FWD_MWB_LD : FWD_MWB_ALU;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ID-stage hazard/forwarding controller: registers EX operand-mux selects and raises
// load-use and mul/div stalls. Optional HAZARD_PERF_EN adds stall-cycle counters.
module hazard_fwd_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int SEL_W  = HZ_SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_hilo,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              id_is_link,
    input  logic              id_md_start,
    input  logic              md_done,
    input  logic              mem_stall,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       perf_lu_cnt,
    output logic [31:0]       perf_md_cnt,
`endif
    output logic              stall_if_id,
    output logic              bubble_ex
);

    localparam int NUM_OPS = 2;  // 0 = operand A (rs), 1 = operand B (rt)

    hz_state_e state_q, state_d;
    dest_rec_t ex_rec, mem_rec, id_rec;

    logic [NUM_OPS-1:0][HZ_REG_AW-1:0] opnd;
    logic [NUM_OPS-1:0]                used;
    logic [NUM_OPS-1:0]                lu_op;
    logic [NUM_OPS-1:0][HZ_SEL_W-1:0]  sel_c;
    logic [NUM_OPS-1:0][HZ_SEL_W-1:0]  sel_q;

    logic lu, hilo_wait, stall, md_accept;

    assign opnd = {HZ_REG_AW'(id_rt), HZ_REG_AW'(id_rs)};
    assign used = {id_uses_rt, id_uses_rs};

    assign id_rec = '{valid:   id_valid,
                      wr_en:   id_wr_en,
                      rd:      HZ_REG_AW'(id_rd),
                      is_load: id_is_load,
                      is_link: id_is_link};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_sel_e sel_e;
        hazard_fwd_cmp u_cmp (
            .ex_rec   (ex_rec),
            .mem_rec  (mem_rec),
            .opnd     (opnd[i]),
            .used     (used[i]),
            .sel      (sel_e),
            .load_use (lu_op[i])
        );
        assign sel_c[i] = sel_e;
    end

    // A second mul/div launch while one is in flight waits like a HI/LO read.
    assign lu        = id_valid && (|lu_op);
    assign hilo_wait = (state_q == HZ_MD_WAIT) && id_valid &&
                       (id_uses_hilo || id_md_start) && !md_done;
    assign stall     = lu || hilo_wait;
    assign md_accept = id_valid && id_md_start && !stall;

    always_comb begin
        state_d     = state_q;
        stall_if_id = stall;
        bubble_ex   = stall;
        if (!mem_stall) begin
            case (state_q)
                HZ_RUN: begin
                    if (lu)             state_d = HZ_LU_STALL;
                    else if (md_accept) state_d = HZ_MD_WAIT;
                end
                HZ_LU_STALL: state_d = md_accept ? HZ_MD_WAIT : HZ_RUN;
                HZ_MD_WAIT: begin
                    // Load-use inside MD_WAIT shares the stall without leaving the state.
                    if (md_done) state_d = md_accept ? HZ_MD_WAIT : HZ_RUN;
                end
                default: state_d = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          state_q <= HZ_RUN;
        else if (!mem_stall) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rec  <= '0;
            mem_rec <= '0;
            sel_q   <= '0;
        end else if (!mem_stall) begin
            mem_rec <= ex_rec;
            ex_rec  <= stall ? '0 : id_rec;
            for (int i = 0; i < NUM_OPS; i++)
                sel_q[i] <= (stall || !id_valid) ? FWD_RF : sel_c[i];
        end
    end

    assign fwd_sel_a = SEL_W'(sel_q[0]);
    assign fwd_sel_b = SEL_W'(sel_q[1]);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_cnt <= '0;
            perf_md_cnt <= '0;
        end else if (!mem_stall) begin
            if (lu)        perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (hilo_wait) perf_md_cnt <= perf_md_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Table-driven bench for hazard_fwd_ctrl: one ID instruction per row, with the
// registered selects from the previous row and this row's stall/bubble as expectations.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_uses_hilo, id_wr_en;
    logic       id_is_load, id_is_link, id_md_start, md_done, mem_stall;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [2:0] fwd_sel_a, fwd_sel_b;
    logic       stall_if_id, bubble_ex;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_md_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_uses_hilo (id_uses_hilo),
        .id_wr_en     (id_wr_en),
        .id_rd        (id_rd),
        .id_is_load   (id_is_load),
        .id_is_link   (id_is_link),
        .id_md_start  (id_md_start),
        .md_done      (md_done),
        .mem_stall    (mem_stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
`ifdef HAZARD_PERF_EN
        .perf_lu_cnt  (perf_lu_cnt),
        .perf_md_cnt  (perf_md_cnt),
`endif
        .stall_if_id  (stall_if_id),
        .bubble_ex    (bubble_ex)
    );

    typedef struct {
        logic       v, urs, urt, hilo, wr, ld, lnk, mds, mdd, mst;
        logic [4:0] rd, rs, rt;
        logic [2:0] ea, eb;
        logic       es;
    } vec_t;

    localparam int NV = 44;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [4:0] rd, rs, rt,
                                input logic urs, urt, wr, ld, lnk, hilo, mds, mdd, mst,
                                input logic [2:0] ea, eb, input logic es);
        vec_t t;
        t.v = v; t.rd = rd; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.wr = wr; t.ld = ld; t.lnk = lnk; t.hilo = hilo; t.mds = mds; t.mdd = mdd;
        t.mst = mst; t.ea = ea; t.eb = eb; t.es = es;
        return t;
    endfunction

    function automatic vec_t alu(input logic [4:0] rd, rs, rt, input logic [2:0] ea, eb,
                                 input logic es);
        return mk(1, rd, rs, rt, 1, 1, 1, 0, 0, 0, 0, 0, 0, ea, eb, es);
    endfunction

    function automatic vec_t lw(input logic [4:0] rd, rs, input logic [2:0] ea, eb,
                                input logic es);
        return mk(1, rd, rs, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, ea, eb, es);
    endfunction

    function automatic vec_t nop(input logic [2:0] ea, eb, input logic mst);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mst, ea, eb, 0);
    endfunction

    function automatic vec_t mfhi(input logic mdd, input logic es);
        return mk(1, 16, 0, 0, 0, 0, 1, 0, 0, 1, 0, mdd, 0, 0, 0, es);
    endfunction

    function automatic vec_t mdop(input logic mdd, input logic es);
        return mk(1, 0, 1, 2, 1, 1, 0, 0, 0, 0, 1, mdd, 0, 0, 0, es);
    endfunction

    task automatic apply(input vec_t t);
        id_valid = t.v; id_rd = t.rd; id_rs = t.rs; id_rt = t.rt;
        id_uses_rs = t.urs; id_uses_rt = t.urt; id_wr_en = t.wr;
        id_is_load = t.ld; id_is_link = t.lnk; id_uses_hilo = t.hilo;
        id_md_start = t.mds; md_done = t.mdd; mem_stall = t.mst;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, got, exp);
        end
    endtask

    initial begin
        // forwarding from EX and MEM
        tbl[0]  = alu(3, 1, 2, 0, 0, 0);
        tbl[1]  = alu(4, 3, 3, 0, 0, 0);
        tbl[2]  = nop(1, 1, 0);
        // load-use on rs
        tbl[3]  = lw(5, 1, 0, 0, 0);
        tbl[4]  = alu(6, 5, 1, 0, 0, 1);
        tbl[5]  = alu(6, 5, 1, 0, 0, 0);
        // r0 producer ignored, MEM ALU forward on rt
        tbl[6]  = alu(0, 1, 2, 3, 0, 0);
        tbl[7]  = alu(8, 0, 6, 0, 0, 0);
        // jal link forward from EX, then from MEM as ALU path
        tbl[8]  = mk(1, 31, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        tbl[9]  = alu(9, 31, 31, 0, 0, 0);
        tbl[10] = alu(10, 31, 2, 4, 4, 0);
        tbl[11] = nop(2, 0, 0);
        // load followed by unused-operand match: no stall
        tbl[12] = lw(11, 1, 0, 0, 0);
        tbl[13] = mk(1, 12, 2, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = nop(0, 0, 0);
        // invalid ID slot after load: no stall
        tbl[15] = lw(13, 2, 0, 0, 0);
        tbl[16] = mk(0, 0, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = nop(0, 0, 0);
        // mem_stall freeze for 3 cycles holds selects
        tbl[18] = alu(14, 1, 2, 0, 0, 0);
        tbl[19] = alu(15, 14, 14, 0, 0, 0);
        tbl[20] = nop(1, 1, 1);
        tbl[21] = nop(1, 1, 1);
        tbl[22] = nop(1, 1, 1);
        tbl[23] = nop(1, 1, 0);
        tbl[24] = nop(0, 0, 0);
        // mult, mfhi two later stalls until md_done coincides
        tbl[25] = mdop(0, 0);
        tbl[26] = nop(0, 0, 0);
        tbl[27] = mfhi(0, 1);
        tbl[28] = mfhi(0, 1);
        tbl[29] = mfhi(0, 1);
        tbl[30] = mfhi(0, 1);
        tbl[31] = mfhi(1, 0);
        tbl[32] = mfhi(0, 0);
        // back-to-back mul/div
        tbl[33] = mdop(0, 0);
        tbl[34] = mdop(0, 1);
        tbl[35] = mdop(1, 0);
        tbl[36] = mfhi(0, 1);
        tbl[37] = mfhi(1, 0);
        tbl[38] = nop(0, 0, 0);
        // load-use and HI/LO wait together
        tbl[39] = mdop(0, 0);
        tbl[40] = lw(18, 1, 0, 0, 0);
        tbl[41] = mk(1, 19, 18, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[42] = mk(1, 19, 18, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[43] = nop(3, 0, 0);

        rst_n = 1'b0;
        apply(nop(0, 0, 0));
        repeat (2) @(negedge clk);
        chk("rst_sel_a", 0, 32'(fwd_sel_a), 0);
        chk("rst_sel_b", 0, 32'(fwd_sel_b), 0);
        chk("rst_stall", 0, 32'(stall_if_id), 0);
        chk("rst_bubble", 0, 32'(bubble_ex), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            @(negedge clk);
            chk("sel_a", i, 32'(fwd_sel_a), 32'(tbl[i].ea));
            chk("sel_b", i, 32'(fwd_sel_b), 32'(tbl[i].eb));
            chk("stall", i, 32'(stall_if_id), 32'(tbl[i].es));
            chk("bubble", i, 32'(bubble_ex), 32'(tbl[i].es));
        end

        // async reset in the middle of a load-use stall with a live EX forward
        @(posedge clk); #1; apply(alu(21, 1, 2, 0, 0, 0));
        @(posedge clk); #1; apply(lw(23, 21, 0, 0, 0));
        @(posedge clk); #1; apply(alu(24, 23, 1, 0, 0, 0));
        @(negedge clk);
        chk("lu_pre_sel_a", 0, 32'(fwd_sel_a), 1);
        chk("lu_pre_stall", 0, 32'(stall_if_id), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("lu_rst_sel_a", 0, 32'(fwd_sel_a), 0);
        chk("lu_rst_sel_b", 0, 32'(fwd_sel_b), 0);
        chk("lu_rst_stall", 0, 32'(stall_if_id), 0);
        chk("lu_rst_bubble", 0, 32'(bubble_ex), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("lu_post_stall", 0, 32'(stall_if_id), 0);
        chk("lu_post_sel_a", 0, 32'(fwd_sel_a), 0);

        // async reset while waiting on mul/div returns the FSM to RUN
        @(posedge clk); #1; apply(mdop(0, 0));
        @(posedge clk); #1; apply(mfhi(0, 1));
        @(negedge clk);
        chk("md_pre_stall", 0, 32'(stall_if_id), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("md_rst_stall", 0, 32'(stall_if_id), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("md_post_stall", 0, 32'(stall_if_id), 0);
        chk("md_post_bubble", 0, 32'(bubble_ex), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
